// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM state type and strobe helpers for the seven-segment reader.
// SEVEN_SEG_READER_BLANK_EN (see seven_seg_to_bcd) makes the all-off pattern decode to BCD_BLANK.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_IDLE   = 4'b1111;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_e;

    // A strobe is usable only when exactly one active-low line is asserted.
    function automatic logic strobe_ok(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

    function automatic logic [1:0] strobe_idx(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_reader_if.sv
// Frame handshake between the reader and its consumer.
// The master drives digits_out/valid and samples ready.
interface seven_seg_reader_if;

    logic [15:0] digits_out;
    logic        valid;
    logic        ready;

    modport master (
        output digits_out,
        output valid,
        input  ready
    );

    modport slave (
        input  digits_out,
        input  valid,
        output ready
    );

endinterface

// File: rtl/seven_seg_to_bcd.sv
// Combinational active-low seven-segment to BCD decoder.
// Define SEVEN_SEG_READER_BLANK_EN to decode the all-off pattern as BCD_BLANK.
module seven_seg_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       bad
);

    always_comb begin
        bcd = BCD_ERR;
        bad = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; bad = 1'b0; end
            SEG_1: begin bcd = 4'd1; bad = 1'b0; end
            SEG_2: begin bcd = 4'd2; bad = 1'b0; end
            SEG_3: begin bcd = 4'd3; bad = 1'b0; end
            SEG_4: begin bcd = 4'd4; bad = 1'b0; end
            SEG_5: begin bcd = 4'd5; bad = 1'b0; end
            SEG_6: begin bcd = 4'd6; bad = 1'b0; end
            SEG_7: begin bcd = 4'd7; bad = 1'b0; end
            SEG_8: begin bcd = 4'd8; bad = 1'b0; end
            SEG_9: begin bcd = 4'd9; bad = 1'b0; end
`ifdef SEVEN_SEG_READER_BLANK_EN
            SEG_BLANK: begin bcd = BCD_BLANK; bad = 1'b0; end
`else
            SEG_BLANK: begin bcd = BCD_ERR; bad = 1'b1; end
`endif
            default: begin bcd = BCD_ERR; bad = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_reader.sv
// Samples a multiplexed 4-digit seven-segment display and emits BCD frames.
// Optional SEVEN_SEG_READER_BLANK_EN enables blank-digit decoding in seven_seg_to_bcd.
module seven_seg_reader
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [6:0]                seg_in,
    input  logic [3:0]                an_in,
    seven_seg_reader_if.master        frame,
    output logic                      err,
    output logic                      overrun
);

    localparam logic [8:0] STABLE_W = 9'(STABLE_CYCLES);

    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic [6:0]  cur_seg_q, cur_seg_d;
    logic [3:0]  cur_an_q, cur_an_d;
    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] slots_q, slots_d;
    logic [15:0] dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;

    logic        strobe_vld;
    logic [1:0]  slot_idx;
    logic [3:0]  dec_bcd;
    logic        dec_bad;
    logic [8:0]  cnt_inc;
    logic        frame_done;
    logic        load;
    logic        cap;

    seven_seg_to_bcd u_dec (
        .seg (seg_q),
        .bcd (dec_bcd),
        .bad (dec_bad)
    );

    assign strobe_vld = strobe_ok(an_q);
    assign slot_idx   = strobe_idx(an_q);
    assign cnt_inc    = {1'b0, cnt_q} + 9'd1;
    assign frame_done = (mask_q == 4'b1111);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q     <= SEG_BLANK;
            an_q      <= AN_IDLE;
            cur_seg_q <= SEG_BLANK;
            cur_an_q  <= AN_IDLE;
            state_q   <= ST_WAIT;
            cnt_q     <= 8'd0;
            mask_q    <= 4'd0;
            slots_q   <= 16'h0000;
            dout_q    <= 16'h0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            seg_q     <= seg_in;
            an_q      <= an_in;
            cur_seg_q <= cur_seg_d;
            cur_an_q  <= cur_an_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            slots_q   <= slots_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_seg_d = cur_seg_q;
        cur_an_d  = cur_an_q;
        load      = 1'b0;
        cap       = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                if (strobe_vld) load = 1'b1;
            end
            ST_SETTLE: begin
                if (!strobe_vld) begin
                    state_d = ST_WAIT;
                end else if (an_q != cur_an_q || seg_q != cur_seg_q) begin
                    load = 1'b1;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (cnt_inc >= STABLE_W) begin
                        cap     = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (!strobe_vld) begin
                    state_d = ST_WAIT;
                end else if (an_q != cur_an_q) begin
                    load = 1'b1;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // A fresh sample counts as the first stable one; with a threshold
        // of one it is accepted immediately.
        if (load) begin
            cur_an_d  = an_q;
            cur_seg_d = seg_q;
            cnt_d     = 8'd1;
            if (STABLE_W == 9'd1) begin
                cap     = 1'b1;
                state_d = ST_HELD;
            end else begin
                state_d = ST_SETTLE;
            end
        end
    end

    always_comb begin
        mask_d  = frame_done ? 4'd0 : mask_q;
        slots_d = slots_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        err_d   = err_q;
        ovr_d   = ovr_q;

        if (cap) begin
            mask_d[slot_idx]                 = 1'b1;
            slots_d[{slot_idx, 2'b00} +: 4]  = dec_bcd;
            if (dec_bad) err_d = 1'b1;
        end

        if (valid_q && frame.ready) valid_d = 1'b0;

        // A completed frame goes out only if the output register is free
        // (or being freed this cycle); otherwise it is dropped.
        if (frame_done) begin
            if (!valid_q || frame.ready) begin
                dout_d  = slots_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign frame.digits_out = dout_q;
    assign frame.valid      = valid_q;
    assign err              = err_q;
    assign overrun          = ovr_q;

endmodule

// File: doc/seven_seg_reader.md
SEVEN_SEG_READER -- requirements
Module: seven_seg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive identical samples needed to accept a digit; legal range 1..255.
REQ-002 Port: clk  in  1  single clock; all logic on rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: seg_in  in  7  segment lines, active-low; bit 6 = A, bit 0 = G.
REQ-005 Port: an_in  in  4  digit strobes, active-low; bit 0 = digit 0 (least significant).
REQ-006 Port: digits_out  out  16  four captured BCD digits; [3:0] = digit 0.
REQ-007 Port: valid  out  1  digits_out holds a complete frame.
REQ-008 Port: ready  in  1  consumer accepts the frame.
REQ-009 Port: err  out  1  sticky; an undecodable pattern was accepted.
REQ-010 Port: overrun  out  1  sticky; a complete frame was dropped.

Function
REQ-011 The block SHALL register seg_in and an_in once before use; all latencies are counted from this register.
REQ-012 The decode SHALL be (A..G, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-013 Any other pattern SHALL decode to 4'hE and set err.
REQ-014 A strobe is valid only when exactly one an_in bit is low; zero or multiple low bits SHALL return the FSM to WAIT.
REQ-015 FSM states: WAIT (no valid strobe), SETTLE (count identical samples), HELD (digit taken; wait for strobe change).
REQ-016 WAIT->SETTLE on a valid strobe, with the counter loaded to 1.
REQ-017 In SETTLE, a change in seg or strobe SHALL reload the counter to 1 and keep the new strobe.
REQ-018 When the count reaches STABLE_CYCLES, the block SHALL write the decoded digit to its slot, set that slot's bit in a 4-bit capture mask, and move to HELD.
REQ-019 HELD->SETTLE on a different valid strobe.
REQ-020 HELD->WAIT on an invalid strobe.
REQ-021 A slot already in the mask SHALL be overwritten by a later capture.
REQ-022 When the mask becomes 4'b1111 and valid is 0, the block SHALL copy the slots to digits_out, assert valid on the next cycle, and clear the mask.
REQ-023 When the mask becomes 4'b1111 and valid is 1 without ready in that cycle, the block SHALL drop the frame, clear the mask, and set overrun.
REQ-024 Handshake: valid falls in the cycle after valid&ready.
REQ-025 Simultaneous frame completion and valid&ready SHALL load the new frame with valid remaining 1.
REQ-026 digits_out SHALL stay stable while valid=1.
REQ-027 err and overrun SHALL clear only on reset.

Reset
REQ-028 On reset_n low, the block SHALL asynchronously force: FSM=WAIT, counter=0, mask=0, slots=0, digits_out=16'h0000, valid=0, err=0, overrun=0.
REQ-029 Reset asserted mid-capture SHALL discard the partial frame; the first frame after release needs all four digits captured again.

Configuration
REQ-030 With SEVEN_SEG_READER_BLANK_EN defined, the pattern 1111111 SHALL decode to 4'hF without setting err.
REQ-031 Without SEVEN_SEG_READER_BLANK_EN, the pattern 1111111 SHALL follow REQ-013 (4'hE, err=1).

Structure
REQ-032 The package seven_seg_pkg SHALL hold the ten segment-pattern constants, the BLANK/ERR code constants (4'hF/4'hE), and the FSM state enum.
REQ-033 The decode SHALL be the combinational sub-module seven_seg_to_bcd (seg[6:0] -> bcd[3:0], bad); the FSM and handshake stay in seven_seg_reader.

Verification
REQ-034 Test: STABLE_CYCLES=4; drive strobes 0..3 low in turn for 6 cycles each, showing 3,0,4,1 -> digits_out=16'h1403 and valid=1 with ready=0, err=0.
REQ-035 Test: hold a digit-2 strobe for 3 cycles, glitch seg, then hold 5 cycles -> slot 2 is captured exactly once, after the glitch plus 4 stable cycles.
REQ-036 Test: seg=0110110 accepted -> slot=4'hE and err=1; err stays 1 after further good frames.
REQ-037 Test: with valid=1 and ready=0, complete a second frame -> overrun=1 and digits_out unchanged; then pulse ready -> valid=0 on the next cycle.
REQ-038 Test: assert ready in the same cycle a new frame completes -> valid stays 1 and digits_out shows the new frame.
REQ-039 Test: seg=1111111 accepted -> slot=4'hF with err=0 when the macro is defined; slot=4'hE with err=1 when it is not.
